// File: rtl/mem_access_unit.sv
// Load/store unit: picks the highest-index ready memory instruction slot, computes
// its address, runs one memory handshake and writes back a stamp and any load result.
module mem_access_unit #(
  parameter int unsigned SLOTS   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*SLOTS-1:0]   reg_start_flat,
  input  logic [88*SLOTS-1:0]  reg_out_flat,
  output logic [3*SLOTS-1:0]   stamp_flat,
  output logic [SLOTS-1:0]     stamp_in,
  output logic [4:0]           reg_search_out10,
  input  logic [31:0]          reg_out10,
  output logic [4:0]           reg_search_out11,
  input  logic [31:0]          reg_out11,
  output logic [4:0]           reg_search_in10,
  output logic [31:0]          reg_in10,
  output logic                 reg_in10_start,
  output logic [31:0]          addr_b,
  output logic [3:0]           addr_b_start,
  output logic [31:0]          addr_b_write,
  input  logic [31:0]          addr_b_read,
  output logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 busy,
  output logic                 fault
);

  localparam int unsigned IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [5:0] OP_LW = 6'b001010;
  localparam logic [5:0] OP_SW = 6'b001011;
  localparam logic [5:0] OP_LB = 6'b001100;
  localparam logic [5:0] OP_SB = 6'b001101;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_MEM, S_WB} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [5:0]         op_q, op_d;
  logic [4:0]         rs_q, rs_d, rt_q, rt_d;
  logic [15:0]        off_q, off_d;
  logic [31:0]        ea_q, ea_d, rtv_q, rtv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mask_q, mask_d;
  logic               flt_d;

  logic [3*SLOTS-1:0] stamp_flat_q, stamp_flat_d;
  logic [SLOTS-1:0]   stamp_in_q, stamp_in_d;
  logic [4:0]         rs_out_q, rs_out_d, rt_out_q, rt_out_d, wr_addr_q, wr_addr_d;
  logic [31:0]        wr_data_q, wr_data_d, addr_q, addr_d, wdata_q, wdata_d;
  logic               wr_en_q, wr_en_d, req_q, req_d, busy_q, busy_d, fault_q, fault_d;
  logic [3:0]         strb_q, strb_d;

  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [5:0]         sel_op;
  logic [4:0]         sel_rs, sel_rt;
  logic [15:0]        sel_off;
  logic [87:0]        slot_instr;
  logic               unused_fields;
  logic [7:0]         ld_byte;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_LB) || (op == OP_SB);
  endfunction

  // Slot scan: later (higher) eligible slots overwrite earlier ones
  always_comb begin
    sel_valid     = 1'b0;
    sel_idx       = '0;
    sel_op        = '0;
    sel_rs        = '0;
    sel_rt        = '0;
    sel_off       = '0;
    slot_instr    = '0;
    unused_fields = 1'b0;
    for (int i = 0; i < int'(SLOTS); i++) begin
      slot_instr    = reg_out_flat[88*i +: 88];
      unused_fields = unused_fields ^ (^{slot_instr[71:67], slot_instr[50:0]});
      if (reg_start_flat[3*i +: 3] == 3'b010 && op_supported(slot_instr[87:82]) &&
          !(mask_q && idx_q == IDX_W'(i))) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_op    = slot_instr[87:82];
        sel_rs    = slot_instr[81:77];
        sel_rt    = slot_instr[76:72];
        sel_off   = slot_instr[66:51];
      end
    end
  end

  always_comb begin
    case (ea_q[1:0])
      2'd0:    ld_byte = addr_b_read[7:0];
      2'd1:    ld_byte = addr_b_read[15:8];
      2'd2:    ld_byte = addr_b_read[23:16];
      default: ld_byte = addr_b_read[31:24];
    endcase
  end

  // Next state, latches and next values of every registered output
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    op_d         = op_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    off_d        = off_q;
    ea_d         = ea_q;
    rtv_d        = rtv_q;
    cnt_d        = '0;
    mask_d       = 1'b0;
    flt_d        = 1'b0;
    stamp_flat_d = '0;
    stamp_in_d   = '0;
    rs_out_d     = '0;
    rt_out_d     = '0;
    wr_addr_d    = '0;
    wr_data_d    = '0;
    wr_en_d      = 1'b0;
    addr_d       = '0;
    strb_d       = '0;
    wdata_d      = '0;
    req_d        = 1'b0;
    fault_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          state_d = S_ADDR;
          idx_d   = sel_idx;
          op_d    = sel_op;
          rs_d    = sel_rs;
          rt_d    = sel_rt;
          off_d   = sel_off;
        end
      end
      S_ADDR: begin
        ea_d  = reg_out10 + {{16{off_q[15]}}, off_q};
        rtv_d = reg_out11;
        if ((op_q == OP_LW || op_q == OP_SW) && ea_d[1:0] != 2'b00) begin
          state_d = S_WB;
          flt_d   = 1'b1;
        end else begin
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_WB;
          flt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        mask_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    if (state_d == S_ADDR) begin
      rs_out_d = rs_d;
      rt_out_d = rt_d;
    end

    // Memory-side outputs stay constant for the whole MEM phase
    if (state_d == S_MEM) begin
      req_d  = 1'b1;
      addr_d = ea_d;
      if (op_q == OP_SW) begin
        strb_d  = 4'b1111;
        wdata_d = rtv_d;
      end else if (op_q == OP_SB) begin
        strb_d  = 4'b0001 << ea_d[1:0];
        wdata_d = {4{rtv_d[7:0]}};
      end
    end

    if (state_d == S_WB) begin
      stamp_in_d[idx_q]                  = 1'b1;
      stamp_flat_d[3*32'(idx_q) +: 3]    = flt_d ? 3'b111 : 3'b011;
      fault_d                            = flt_d;
      if (!flt_d && (op_q == OP_LW || op_q == OP_LB) && rt_q != 5'd0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = rt_q;
        wr_data_d = (op_q == OP_LB) ? {{24{ld_byte[7]}}, ld_byte} : addr_b_read;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      op_q         <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      off_q        <= '0;
      ea_q         <= '0;
      rtv_q        <= '0;
      cnt_q        <= '0;
      mask_q       <= 1'b0;
      stamp_flat_q <= '0;
      stamp_in_q   <= '0;
      rs_out_q     <= '0;
      rt_out_q     <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      strb_q       <= '0;
      wdata_q      <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      off_q        <= off_d;
      ea_q         <= ea_d;
      rtv_q        <= rtv_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      stamp_flat_q <= stamp_flat_d;
      stamp_in_q   <= stamp_in_d;
      rs_out_q     <= rs_out_d;
      rt_out_q     <= rt_out_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      strb_q       <= strb_d;
      wdata_q      <= wdata_d;
      req_q        <= req_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign stamp_flat       = stamp_flat_q;
  assign stamp_in         = stamp_in_q;
  assign reg_search_out10 = rs_out_q;
  assign reg_search_out11 = rt_out_q;
  assign reg_search_in10  = wr_addr_q;
  assign reg_in10         = wr_data_q;
  assign reg_in10_start   = wr_en_q;
  assign addr_b           = addr_q;
  assign addr_b_start     = strb_q;
  assign addr_b_write     = wdata_q;
  assign mem_req          = req_q;
  assign busy             = busy_q;
  assign fault            = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a register-file model and a memory
// responder whose ready latency is set per test.
module tb_mem_access_unit;

  localparam int unsigned SLOTS = 8;

  localparam logic [5:0] OP_LW = 6'b001010;
  localparam logic [5:0] OP_SW = 6'b001011;
  localparam logic [5:0] OP_LB = 6'b001100;
  localparam logic [5:0] OP_SB = 6'b001101;

  logic                clk = 1'b0;
  logic                rst;
  logic [3*SLOTS-1:0]  reg_start_flat;
  logic [88*SLOTS-1:0] reg_out_flat;
  logic [3*SLOTS-1:0]  stamp_flat;
  logic [SLOTS-1:0]    stamp_in;
  logic [4:0]          reg_search_out10, reg_search_out11, reg_search_in10;
  logic [31:0]         reg_out10, reg_out11, reg_in10;
  logic                reg_in10_start;
  logic [31:0]         addr_b, addr_b_write, addr_b_read;
  logic [3:0]          addr_b_start;
  logic                mem_req, mem_ready, busy, fault;

  logic [31:0] rf [32];
  logic [31:0] mem_data;
  int          ready_lat;
  int          mem_cnt = 0;

  int checks = 0;
  int errors = 0;

  int          o_lat, o_req_cyc, o_flt_cyc, o_wr_cyc;
  bit          o_done;
  logic [31:0] o_addr, o_wdata, o_wr_data;
  logic [3:0]  o_strb;
  logic [4:0]  o_wr_addr;
  logic [7:0]  o_stamp_in;
  logic [23:0] o_stamp_flat;

  mem_access_unit #(.SLOTS(SLOTS), .TIMEOUT(16)) dut (
    .clk              (clk),
    .rst              (rst),
    .reg_start_flat   (reg_start_flat),
    .reg_out_flat     (reg_out_flat),
    .stamp_flat       (stamp_flat),
    .stamp_in         (stamp_in),
    .reg_search_out10 (reg_search_out10),
    .reg_out10        (reg_out10),
    .reg_search_out11 (reg_search_out11),
    .reg_out11        (reg_out11),
    .reg_search_in10  (reg_search_in10),
    .reg_in10         (reg_in10),
    .reg_in10_start   (reg_in10_start),
    .addr_b           (addr_b),
    .addr_b_start     (addr_b_start),
    .addr_b_write     (addr_b_write),
    .addr_b_read      (addr_b_read),
    .mem_req          (mem_req),
    .mem_ready        (mem_ready),
    .busy             (busy),
    .fault            (fault)
  );

  always #5 clk = ~clk;

  assign reg_out10   = rf[reg_search_out10];
  assign reg_out11   = rf[reg_search_out11];
  assign addr_b_read = mem_data;
  assign mem_ready   = mem_req && (mem_cnt == ready_lat);

  always @(posedge clk) begin
    if (!mem_req || mem_ready) mem_cnt <= 0;
    else                       mem_cnt <= mem_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [87:0] mk_instr(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] off);
    logic [87:0] v;
    v          = '0;
    v[87:82]   = op;
    v[81:77]   = rs;
    v[76:72]   = rt;
    v[66:51]   = off;
    return v;
  endfunction

  task automatic set_slot(input int s, input logic [5:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [15:0] off);
    reg_out_flat[88*s +: 88] = mk_instr(op, rs, rt, off);
    reg_start_flat[3*s +: 3] = 3'b010;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Follow one operation until its stamp appears; clr scrambles the slots after select
  task run_op(input bit clr);
    o_done = 0; o_lat = -1; o_req_cyc = 0; o_flt_cyc = 0; o_wr_cyc = 0;
    o_addr = '0; o_wdata = '0; o_strb = '0; o_wr_addr = '0; o_wr_data = '0;
    o_stamp_in = '0; o_stamp_flat = '0;
    for (int c = 0; c < 60 && !o_done; c++) begin
      @(negedge clk);
      if (c == 0 && clr) begin
        reg_start_flat = '0;
        reg_out_flat   = '1;
      end
      if (mem_req) begin
        o_req_cyc++;
        o_addr  = addr_b;
        o_strb  = addr_b_start;
        o_wdata = addr_b_write;
      end
      if (fault) o_flt_cyc++;
      if (reg_in10_start) begin
        o_wr_cyc++;
        o_wr_addr = reg_search_in10;
        o_wr_data = reg_in10;
      end
      if (stamp_in != '0) begin
        o_done       = 1;
        o_lat        = c;
        o_stamp_in   = stamp_in;
        o_stamp_flat = stamp_flat;
      end
    end
    chk("op_done", 64'(o_done), 64'd1);
  endtask

  initial begin
    int seen;
    rst            = 1'b1;
    reg_start_flat = '0;
    reg_out_flat   = '0;
    mem_data       = '0;
    ready_lat      = 0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[2] = 32'h0000_0100;
    rf[3] = 32'h0000_0203;
    rf[4] = 32'h0000_00AB;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_stamp", 64'({stamp_in, stamp_flat}), 64'd0);
    chk("rst_outs", {addr_b, addr_b_start, reg_in10_start, fault, 26'(reg_search_out10)}, 64'd0);
    rst = 1'b0;
    idle(2);

    // LW, aligned, ready in first MEM cycle
    set_slot(3, OP_LW, 5'd2, 5'd5, 16'd4);
    mem_data = 32'hDEAD_BEEF;
    run_op(1);
    chk("lw_addr", 64'(o_addr), 64'h104);
    chk("lw_strb", 64'(o_strb), 64'h0);
    chk("lw_req_cyc", 64'(o_req_cyc), 64'd1);
    chk("lw_wr_cyc", 64'(o_wr_cyc), 64'd1);
    chk("lw_wr_addr", 64'(o_wr_addr), 64'd5);
    chk("lw_wr_data", 64'(o_wr_data), 64'hDEAD_BEEF);
    chk("lw_stamp_in", 64'(o_stamp_in), 64'h08);
    chk("lw_stamp_flat", 64'(o_stamp_flat), 64'h600);
    chk("lw_fault", 64'(o_flt_cyc), 64'd0);
    chk("lw_latency", 64'(o_lat), 64'd2);
    idle(2);

    // SB to byte lane 3
    set_slot(2, OP_SB, 5'd3, 5'd4, 16'd0);
    mem_data = 32'h0;
    run_op(1);
    chk("sb_addr", 64'(o_addr), 64'h203);
    chk("sb_strb", 64'(o_strb), 64'h8);
    chk("sb_wdata", 64'(o_wdata), 64'hABAB_ABAB);
    chk("sb_wr_cyc", 64'(o_wr_cyc), 64'd0);
    chk("sb_stamp_flat", 64'(o_stamp_flat), 64'h0C0);
    idle(2);

    // SW full word
    set_slot(0, OP_SW, 5'd2, 5'd3, 16'd8);
    run_op(1);
    chk("sw_addr", 64'(o_addr), 64'h108);
    chk("sw_strb", 64'(o_strb), 64'hF);
    chk("sw_wdata", 64'(o_wdata), 64'h203);
    chk("sw_stamp_flat", 64'(o_stamp_flat), 64'h003);
    idle(2);

    // Priority: slot 6 then slot 1, slots left eligible throughout
    reg_out_flat = '0;
    set_slot(1, OP_LW, 5'd2, 5'd8, 16'd0);
    set_slot(6, OP_LW, 5'd2, 5'd9, 16'd0);
    mem_data = 32'h1122_3344;
    run_op(0);
    chk("prio1_stamp_in", 64'(o_stamp_in), 64'h40);
    chk("prio1_wr_addr", 64'(o_wr_addr), 64'd9);
    run_op(0);
    chk("prio2_stamp_in", 64'(o_stamp_in), 64'h02);
    chk("prio2_wr_addr", 64'(o_wr_addr), 64'd8);
    chk("prio2_latency", 64'(o_lat), 64'd3);
    reg_start_flat = '0;
    idle(2);

    // Misaligned LW
    set_slot(0, OP_LW, 5'd2, 5'd5, 16'd2);
    run_op(1);
    chk("mis_fault", 64'(o_flt_cyc), 64'd1);
    chk("mis_req_cyc", 64'(o_req_cyc), 64'd0);
    chk("mis_stamp_flat", 64'(o_stamp_flat), 64'h007);
    chk("mis_wr_cyc", 64'(o_wr_cyc), 64'd0);
    idle(2);

    // Timeout: memory never answers
    ready_lat = 1000;
    set_slot(5, OP_LW, 5'd2, 5'd5, 16'd0);
    run_op(1);
    chk("to_req_cyc", 64'(o_req_cyc), 64'd16);
    chk("to_fault", 64'(o_flt_cyc), 64'd1);
    chk("to_stamp_flat", 64'(o_stamp_flat), 64'h38000);
    chk("to_stamp_in", 64'(o_stamp_in), 64'h20);
    chk("to_wr_cyc", 64'(o_wr_cyc), 64'd0);
    ready_lat = 0;
    idle(2);

    // LB into r0: no write
    set_slot(4, OP_LB, 5'd2, 5'd0, 16'd1);
    mem_data = 32'h0000_8000;
    run_op(1);
    chk("lb0_addr", 64'(o_addr), 64'h101);
    chk("lb0_wr_cyc", 64'(o_wr_cyc), 64'd0);
    chk("lb0_stamp_flat", 64'(o_stamp_flat), 64'h3000);
    idle(2);

    // LB negative offset, byte lane 3, sign extension
    set_slot(7, OP_LB, 5'd2, 5'd7, 16'hFFFF);
    mem_data = 32'h8000_0000;
    run_op(1);
    chk("lb7_addr", 64'(o_addr), 64'hFF);
    chk("lb7_wr_addr", 64'(o_wr_addr), 64'd7);
    chk("lb7_wr_data", 64'(o_wr_data), 64'hFFFF_FF80);
    chk("lb7_stamp_flat", 64'(o_stamp_flat), 64'h60_0000);
    idle(2);

    // Ineligible slots: unsupported opcode, and wrong status
    reg_out_flat = '0;
    set_slot(2, 6'b000000, 5'd2, 5'd5, 16'd0);
    set_slot(3, OP_LW, 5'd2, 5'd5, 16'd0);
    reg_start_flat[9 +: 3] = 3'b011;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("inelig_busy", 64'(seen), 64'd0);
    reg_start_flat = '0;
    idle(1);

    // Reset during MEM
    ready_lat = 1000;
    set_slot(6, OP_LW, 5'd2, 5'd5, 16'd0);
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    chk("rmem_reached", 64'(seen), 64'd1);
    reg_start_flat = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("rmem_req", 64'(mem_req), 64'd0);
    chk("rmem_busy", 64'(busy), 64'd0);
    chk("rmem_stamp", 64'(stamp_in), 64'd0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (stamp_in != '0 || reg_in10_start || busy) seen++;
    end
    chk("rmem_quiet", 64'(seen), 64'd0);
    ready_lat = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
